// File: rtl/aes_round_ctrl.sv
// ----------------------------------------------------------------------------
// aes_round_ctrl
//
// Iterative AES-128 encryption sequencer. It accepts one plaintext block,
// applies the initial AddRoundKey, then steps a shared external round
// datapath through nine full rounds and one final round (no MixColumns).
// Round keys come from an external key store that is indexed by rk_idx.
//
// Optional feature: define AES_CTRL_ABORT_EN to add a synchronous 'abort'
// input. An abort cancels an in-flight block and returns the sequencer to IDLE.
//
// Ports:
//   clk        system clock (rising edge)
//   rst        asynchronous active-high reset
//   in_valid   plaintext block offered
//   in_ready   high only in IDLE
//   in_block   128-bit plaintext
//   rk_idx     round-key index to key store (0..10)
//   rk         round key for rk_idx (combinational from key store)
//   dp_state   cipher state fed to the round datapath
//   dp_last    selects the final-round variant of the datapath
//   dp_result  combinational datapath output
//   out_valid  ciphertext available
//   out_ready  consumer accepts ciphertext
//   out_data   128-bit ciphertext, held while out_valid is high
//   busy       high in ROUND, LAST and DONE
//   abort      (AES_CTRL_ABORT_EN only) cancel the current block
// ----------------------------------------------------------------------------
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic [127:0] dp_state,
    output logic         dp_last,
    input  logic [127:0] dp_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
`ifdef AES_CTRL_ABORT_EN
    ,
    input  logic         abort
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_LAST  = 2'd2,
        S_DONE  = 2'd3
    } fsm_t;

    // Last full-round count, and the key index used by the final round.
    localparam logic [3:0] CNT_LAST = 4'(NR - 1);
    localparam logic [3:0] RK_LAST  = 4'(NR);

    fsm_t         fsm_reg;
    logic [3:0]   cnt_reg;
    logic [127:0] state_reg;
    logic [127:0] out_data_reg;
    logic         out_valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_reg       <= S_IDLE;
            cnt_reg       <= '0;
            state_reg     <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else
`ifdef AES_CTRL_ABORT_EN
        // Abort wins over the round update and over the output handshake;
        // in IDLE it is ignored so a simultaneous transfer still proceeds.
        if (abort && (fsm_reg != S_IDLE)) begin
            fsm_reg       <= S_IDLE;
            cnt_reg       <= '0;
            state_reg     <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else
`endif
        begin
            case (fsm_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        // Initial AddRoundKey uses round key 0.
                        state_reg <= in_block ^ rk;
                        cnt_reg   <= 4'd1;
                        fsm_reg   <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    state_reg <= dp_result;
                    if (cnt_reg == CNT_LAST) begin
                        fsm_reg <= S_LAST;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                S_LAST: begin
                    // The final round result goes straight to the output register.
                    out_data_reg  <= dp_result;
                    out_valid_reg <= 1'b1;
                    fsm_reg       <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= '0;
                        cnt_reg       <= '0;
                        fsm_reg       <= S_IDLE;
                    end
                end
                default: begin
                    fsm_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Key index and round variant depend only on registered state, so no
    // handshake input reaches them combinationally.
    always_comb begin
        rk_idx  = 4'd0;
        dp_last = 1'b0;
        case (fsm_reg)
            S_ROUND: rk_idx = cnt_reg;
            S_LAST: begin
                rk_idx  = RK_LAST;
                dp_last = 1'b1;
            end
            default: begin
                rk_idx  = 4'd0;
                dp_last = 1'b0;
            end
        endcase
    end

    assign in_ready  = (fsm_reg == S_IDLE);
    assign busy      = (fsm_reg != S_IDLE);
    assign dp_state  = state_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule
